uart_tx_arbiter: RTL and testbench

//  Shares one 8N1 UART transmitter between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-granular sharing of one 8N1 UART transmitter
//            byte interface between NUM_REQ valid/ready byte-stream producers.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_data_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_data_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_IDX_W = c_ID_W + 1;
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [c_ID_W-1:0]  c_LAST_ID = c_ID_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_IDX_W-1:0] c_NUM_REQ = c_IDX_W'(NUM_REQ);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [c_ID_W-1:0]   r_grant_id;
  logic [c_CNT_W-1:0]  r_burst_cnt;

  logic [7:0]          w_req_bytes [NUM_REQ];
  logic [c_ID_W-1:0]   w_winner;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_active;
  logic                w_xfer;
  logic                w_release;
  logic [c_ID_W-1:0]   w_next_ptr;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Scan offsets from highest to lowest so the nearest valid requester at or
  // above the pointer (with wrap) is the one left in w_winner.
  always_comb begin
    w_winner = r_rr_ptr;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
      if (w_idx >= c_NUM_REQ) begin
        w_idx = w_idx - c_NUM_REQ;
      end
      if (req_valid[w_idx[c_ID_W-1:0]]) begin
        w_winner = w_idx[c_ID_W-1:0];
      end
    end
  end

  // Gated by rst_n so nothing is accepted in a cycle where reset abandons a grant.
  assign w_active = rst_n && (r_state == S_GRANT);

  always_comb begin
    tx_data_valid = 1'b0;
    tx_data       = 8'h00;
    req_ready     = '0;
    if (w_active) begin
      tx_data_valid         = req_valid[r_grant_id];
      tx_data               = w_req_bytes[r_grant_id];
      req_ready[r_grant_id] = tx_data_ready;
    end
  end

  assign w_xfer     = w_active && req_valid[r_grant_id] && tx_data_ready;
  assign w_release  = w_xfer && (req_last[r_grant_id] || (r_burst_cnt == c_CNT_MAX));
  assign w_next_ptr = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant_id  <= w_winner;
            r_burst_cnt <= '0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= w_next_ptr;
            r_burst_cnt <= '0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed and randomized bench for uart_tx_arbiter against a
//            packet-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_data_valid;
  logic [7:0]     tx_data;
  logic           tx_data_ready;
  logic [1:0]     grant_id;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // Per-requester pending bytes, and the model's view of the round-robin pointer
  logic [7:0] q_data [N][$];
  bit         q_last [N][$];
  logic [7:0] md     [N][$];
  bit         ml     [N][$];
  int         m_ptr;
  int         exp_id[$];
  logic [7:0] exp_byte[$];
  int         got_id[$];
  logic [7:0] got_byte[$];
  bit         m_locked;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    req_data      = '0;
    tx_data_ready = 1'b0;
    clear_queues();
    tick();
    rst_n = 1'b1;
    #1;
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_grant_id"},  grant_id, 0);
    chk({tag, "_tx_valid"},  tx_data_valid, 0);
    chk({tag, "_tx_data"},   tx_data, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    m_ptr = 0;
  endtask

  task automatic add_pkt(input int r, input int len, input bit with_last, input bit rnd,
                         input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      q_data[r].push_back(rnd ? 8'($urandom) : base + 8'(k));
      q_last[r].push_back(with_last && (k == len - 1));
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (q_data[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Expected byte stream: round-robin over non-empty requesters, each grant
  // running until a last-flagged byte or MAXB bytes, pointer moving past the winner.
  task automatic build_expected();
    int  w;
    int  n;
    bit  done;
    bit  lf;
    exp_id.delete();
    exp_byte.delete();
    m_locked = 1'b0;
    for (int i = 0; i < N; i++) begin
      md[i] = q_data[i];
      ml[i] = q_last[i];
    end
    forever begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && md[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
      end
      if (w < 0) break;
      n    = 0;
      done = 1'b0;
      while (!done && md[w].size() > 0) begin
        exp_id.push_back(w);
        exp_byte.push_back(md[w].pop_front());
        lf = ml[w].pop_front();
        n++;
        if (lf || n == MAXB) done = 1'b1;
      end
      if (!done) begin
        m_locked = 1'b1;
        break;
      end
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic run_engine(input string tag, input int ready_pct, input bit allow_drop);
    int   cyc;
    int   idle_run;
    bit   xfer;
    int   xid;
    got_id.delete();
    got_byte.delete();
    cyc      = 0;
    idle_run = 0;
    while (any_pending()) begin
      if (cyc > 3000) begin
        chk({tag, "_timeout"}, 0, 1);
        break;
      end
      for (int i = 0; i < N; i++) begin
        if (q_data[i].size() > 0) begin
          req_data[8*i +: 8] = q_data[i][0];
          req_last[i]        = q_last[i][0];
          req_valid[i]       = (busy && allow_drop) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom);
          req_valid[i]       = 1'b0;
        end
      end
      tx_data_ready = ($urandom_range(1, 100) <= ready_pct);
      #1;
      chk({tag, "_onehot0"}, $onehot0(req_ready), 1);
      if (!busy) begin
        chk({tag, "_idle_quiet"}, tx_data_valid, 0);
        idle_run++;
        chk({tag, "_arb_latency"}, idle_run <= 1, 1);
      end else begin
        idle_run = 0;
      end
      xfer = tx_data_valid && tx_data_ready;
      xid  = int'(grant_id);
      if (xfer) begin
        chk({tag, "_ready_sel"}, req_ready, 4'b0001 << xid);
        got_id.push_back(xid);
        got_byte.push_back(tx_data);
      end
      tick();
      if (xfer && q_data[xid].size() > 0) begin
        void'(q_data[xid].pop_front());
        void'(q_last[xid].pop_front());
      end
      cyc++;
    end
    req_valid     = '0;
    tx_data_ready = 1'b0;
    #1;
    chk({tag, "_len"}, got_id.size(), exp_id.size());
    for (int k = 0; k < got_id.size() && k < exp_id.size(); k++) begin
      chk($sformatf("%s_id[%0d]", tag, k), got_id[k], exp_id[k]);
      chk($sformatf("%s_byte[%0d]", tag, k), got_byte[k], exp_byte[k]);
    end
    chk({tag, "_end_busy"}, busy, m_locked);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    req_data      = '0;
    tx_data_ready = 1'b0;
    do_reset("reset");

    // T1: single byte, 1-cycle arbitration, one-cycle busy pulse
    req_valid     = 4'b0001;
    req_data[7:0] = 8'hA5;
    req_last      = 4'b0001;
    tx_data_ready = 1'b1;
    #1;
    chk("t1_arb_busy", busy, 0);
    chk("t1_arb_tx_valid", tx_data_valid, 0);
    chk("t1_arb_ready", req_ready, 0);
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_id, 0);
    chk("t1_tx_valid", tx_data_valid, 1);
    chk("t1_tx_data", tx_data, 8'hA5);
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("t1_rel_busy", busy, 0);
    chk("t1_rel_tx_valid", tx_data_valid, 0);
    tick();
    chk("t1_idle_busy", busy, 0);
    m_ptr = 1;

    // Pointer now at 1: req1 should beat req0
    add_pkt(0, 1, 1, 0, 8'h01);
    add_pkt(1, 1, 1, 0, 8'h11);
    build_expected();
    run_engine("t1_ptr", 100, 0);

    // T2: two requesters with 2-byte packets from reset, req0 has a second packet
    do_reset("t2_reset");
    add_pkt(0, 2, 1, 0, 8'h20);
    add_pkt(0, 2, 1, 0, 8'h28);
    add_pkt(1, 2, 1, 0, 8'h30);
    build_expected();
    run_engine("t2", 100, 0);

    // T4: transmitter stalls 20 cycles while req3 holds 0x3C
    req_valid          = 4'b1000;
    req_data[31:24]    = 8'h3C;
    req_last           = 4'b1000;
    tx_data_ready      = 1'b0;
    tick();
    chk("t4_grant", grant_id, 3);
    chk("t4_busy", busy, 1);
    for (int c = 0; c < 20; c++) begin
      chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_data", tx_data, 8'h3C);
      tick();
    end
    tx_data_ready = 1'b1;
    #1;
    chk("t4_go_ready", req_ready, 4'b1000);
    tick();
    req_valid     = '0;
    tx_data_ready = 1'b0;
    #1;
    chk("t4_rel_busy", busy, 0);
    m_ptr = 0;

    // T3: 6 bytes without last, cap 4 -> release, re-grant, then grant stays locked
    add_pkt(2, 6, 0, 0, 8'h60);
    build_expected();
    run_engine("t3", 100, 0);
    chk("t3_locked_grant", grant_id, 2);

    // T5: reset during the second byte of a 5-byte packet
    do_reset("t5_pre_reset");
    req_valid        = 4'b0010;
    req_data[15:8]   = 8'h10;
    req_last         = 4'b0000;
    tx_data_ready    = 1'b1;
    tick();
    chk("t5_grant", grant_id, 1);
    tick();
    req_data[15:8] = 8'h11;
    rst_n          = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_tx_valid", tx_data_valid, 0);
    tick();
    rst_n         = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_tx_valid", tx_data_valid, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_req_ready", req_ready, 0);
    req_valid     = 4'b0011;
    req_data[7:0] = 8'h20;
    req_last      = 4'b0001;
    tick();
    chk("t5_rearb_grant", grant_id, 0);
    chk("t5_rearb_data", tx_data, 8'h20);
    do_reset("t5_post_reset");

    // T6: drive the pointer to 3, then req0 and req3 compete across the wrap
    add_pkt(2, 1, 1, 0, 8'h70);
    build_expected();
    run_engine("t6_setup", 100, 0);
    add_pkt(0, 2, 1, 0, 8'h80);
    add_pkt(3, 1, 1, 0, 8'h90);
    build_expected();
    run_engine("t6_wrap", 100, 0);

    // Randomized multi-requester traffic with stalls and valid gaps
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) add_pkt(i, $urandom_range(1, 7), 1, 1, 8'h00);
      end
      if (!any_pending()) add_pkt($urandom_range(0, N - 1), 3, 1, 1, 8'h00);
      build_expected();
      run_engine($sformatf("rnd%0d", r), 70, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
